// File: rtl/warp_scalar_reg_file_pkg.sv
// Shared types and constants for the multi-warp scalar register file.
// Holds the write-back source select and the reserved register indices.
package warp_scalar_reg_file_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_NUM_WARPS  = 4;
  localparam int DEFAULT_NUM_REGS   = 32;
  localparam int DEFAULT_PC_WIDTH   = 12;

  localparam int ZERO_REG           = 0;
  localparam int EXECUTION_MASK_REG = 1;

  typedef enum logic [2:0] {
    ALU_OUT          = 3'd0,
    LSU_OUT          = 3'd1,
    IMMEDIATE        = 3'd2,
    PC_PLUS_1        = 3'd3,
    VECTOR_TO_SCALAR = 3'd4
  } reg_input_mux_t;

  // A single warp still needs a one-bit warp index.
  function automatic int idWidth(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  typedef logic [idWidth(DEFAULT_NUM_WARPS)-1:0] warp_id_t;
  typedef logic [$clog2(DEFAULT_NUM_REGS)-1:0]   reg_addr_t;

  function automatic logic isLegalMux(input reg_input_mux_t sel);
    case (sel)
      ALU_OUT, LSU_OUT, IMMEDIATE, PC_PLUS_1, VECTOR_TO_SCALAR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/warp_scalar_reg_file_if.sv
// Bus between the scheduler/decoder, the write-back path and the register file.
interface warp_scalar_reg_file_if
  import warp_scalar_reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_WARPS  = DEFAULT_NUM_WARPS,
  parameter int NUM_REGS   = DEFAULT_NUM_REGS,
  parameter int PC_WIDTH   = DEFAULT_PC_WIDTH
);
  localparam int WID = idWidth(NUM_WARPS);
  localparam int RID = $clog2(NUM_REGS);

  logic                  rd_req_valid;
  logic [WID-1:0]        rd_warp;
  logic [RID-1:0]        rs1_addr;
  logic [RID-1:0]        rs2_addr;
  logic                  rd_resp_valid;
  logic [DATA_WIDTH-1:0] rs1_data;
  logic [DATA_WIDTH-1:0] rs2_data;
  logic                  rs_hazard;

  logic                  issue_valid;
  logic [WID-1:0]        issue_warp;
  logic [RID-1:0]        issue_rd;

  logic                  wb_valid;
  logic [WID-1:0]        wb_warp;
  logic [RID-1:0]        wb_rd;
  reg_input_mux_t        wb_mux;
  logic [DATA_WIDTH-1:0] alu_out;
  logic [DATA_WIDTH-1:0] lsu_out;
  logic [DATA_WIDTH-1:0] wb_immediate;
  logic [PC_WIDTH-1:0]   pc;
  logic [DATA_WIDTH-1:0] vector_to_scalar_data;

  logic [WID-1:0]        mask_warp;
  logic [DATA_WIDTH-1:0] exec_mask;
  logic                  illegal_mux;

  modport master (
    output rd_req_valid, rd_warp, rs1_addr, rs2_addr,
    output issue_valid, issue_warp, issue_rd,
    output wb_valid, wb_warp, wb_rd, wb_mux, alu_out, lsu_out, wb_immediate, pc,
    output vector_to_scalar_data, mask_warp,
    input  rd_resp_valid, rs1_data, rs2_data, rs_hazard, exec_mask, illegal_mux
  );

  modport slave (
    input  rd_req_valid, rd_warp, rs1_addr, rs2_addr,
    input  issue_valid, issue_warp, issue_rd,
    input  wb_valid, wb_warp, wb_rd, wb_mux, alu_out, lsu_out, wb_immediate, pc,
    input  vector_to_scalar_data, mask_warp,
    output rd_resp_valid, rs1_data, rs2_data, rs_hazard, exec_mask, illegal_mux
  );

endinterface

// File: rtl/warp_scalar_reg_file_reg_scoreboard.sv
// Pending-write bits for every warp/register, with two hazard lookups that
// already see this cycle's write-back clear but not this cycle's reservation.
module warp_scalar_reg_file_reg_scoreboard
  import warp_scalar_reg_file_pkg::*;
#(
  parameter int NUM_WARPS = DEFAULT_NUM_WARPS,
  parameter int NUM_REGS  = DEFAULT_NUM_REGS,
  localparam int WID = idWidth(NUM_WARPS),
  localparam int RID = $clog2(NUM_REGS)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_setValid,
  input  logic [WID-1:0] i_setWarp,
  input  logic [RID-1:0] i_setReg,
  input  logic           i_clrValid,
  input  logic [WID-1:0] i_clrWarp,
  input  logic [RID-1:0] i_clrReg,
  input  logic [WID-1:0] i_lookupWarp,
  input  logic [RID-1:0] i_lookupReg1,
  input  logic [RID-1:0] i_lookupReg2,
  output logic           o_pending1,
  output logic           o_pending2
);

  logic [NUM_REGS-1:0] r_pending [NUM_WARPS];

  logic w_setEn;
  logic w_clrEn;
  logic w_lookupInRange;

  assign w_setEn = i_setValid && (i_setReg != RID'(ZERO_REG)) && (int'(i_setWarp) < NUM_WARPS);
  assign w_clrEn = i_clrValid && (i_clrReg != RID'(ZERO_REG)) && (int'(i_clrWarp) < NUM_WARPS);
  assign w_lookupInRange = int'(i_lookupWarp) < NUM_WARPS;

  // The set is scheduled last so a same-cycle reservation wins over the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        r_pending[w] <= '0;
      end
    end else begin
      if (w_clrEn) begin
        r_pending[i_clrWarp][i_clrReg] <= 1'b0;
      end
      if (w_setEn) begin
        r_pending[i_setWarp][i_setReg] <= 1'b1;
      end
    end
  end

  always_comb begin
    o_pending1 = 1'b0;
    o_pending2 = 1'b0;
    if (w_lookupInRange) begin
      o_pending1 = r_pending[i_lookupWarp][i_lookupReg1] &&
                   !(w_clrEn && (i_clrWarp == i_lookupWarp) && (i_clrReg == i_lookupReg1));
      o_pending2 = r_pending[i_lookupWarp][i_lookupReg2] &&
                   !(w_clrEn && (i_clrWarp == i_lookupWarp) && (i_clrReg == i_lookupReg2));
    end
  end

endmodule

// File: rtl/warp_scalar_reg_file.sv
// Banked scalar register file for all warps: registered dual read with
// write-back bypass, pending-write hazard flag and per-warp execution mask.
module warp_scalar_reg_file
  import warp_scalar_reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_WARPS  = DEFAULT_NUM_WARPS,
  parameter int NUM_REGS   = DEFAULT_NUM_REGS,
  parameter int PC_WIDTH   = DEFAULT_PC_WIDTH
) (
  input logic                    clk,
  input logic                    reset,
  warp_scalar_reg_file_if.slave  bus
);

  localparam int WID = idWidth(NUM_WARPS);
  localparam int RID = $clog2(NUM_REGS);

  logic [DATA_WIDTH-1:0] r_regs [NUM_WARPS][NUM_REGS];
  logic                  r_respValid;
  logic [DATA_WIDTH-1:0] r_rs1Data;
  logic [DATA_WIDTH-1:0] r_rs2Data;
  logic                  r_hazard;
  logic                  r_illegalMux;

  logic [PC_WIDTH-1:0]   w_pcPlus1;
  logic [DATA_WIDTH-1:0] w_wbData;
  logic                  w_wbLegal;
  logic                  w_wbWrite;
  logic                  w_rdInRange;
  logic                  w_maskInRange;
  logic [DATA_WIDTH-1:0] w_rs1Value;
  logic [DATA_WIDTH-1:0] w_rs2Value;
  logic                  w_pending1;
  logic                  w_pending2;

  assign w_pcPlus1     = bus.pc + 1'b1;
  assign w_wbLegal     = isLegalMux(bus.wb_mux);
  assign w_wbWrite     = bus.wb_valid && w_wbLegal && (bus.wb_rd != RID'(ZERO_REG)) &&
                         (int'(bus.wb_warp) < NUM_WARPS);
  assign w_rdInRange   = int'(bus.rd_warp) < NUM_WARPS;
  assign w_maskInRange = int'(bus.mask_warp) < NUM_WARPS;

  always_comb begin
    w_wbData = '0;
    case (bus.wb_mux)
      ALU_OUT:          w_wbData = bus.alu_out;
      LSU_OUT:          w_wbData = bus.lsu_out;
      IMMEDIATE:        w_wbData = bus.wb_immediate;
      PC_PLUS_1:        w_wbData = DATA_WIDTH'(w_pcPlus1);
      VECTOR_TO_SCALAR: w_wbData = bus.vector_to_scalar_data;
      default:          w_wbData = '0;
    endcase
  end

  // Source reads: reg0 and out-of-range warps read zero; a matching write-back is forwarded.
  always_comb begin
    w_rs1Value = '0;
    w_rs2Value = '0;
    if (w_rdInRange) begin
      if (bus.rs1_addr != RID'(ZERO_REG)) begin
        if (w_wbWrite && (bus.wb_warp == bus.rd_warp) && (bus.wb_rd == bus.rs1_addr)) begin
          w_rs1Value = w_wbData;
        end else begin
          w_rs1Value = r_regs[bus.rd_warp][bus.rs1_addr];
        end
      end
      if (bus.rs2_addr != RID'(ZERO_REG)) begin
        if (w_wbWrite && (bus.wb_warp == bus.rd_warp) && (bus.wb_rd == bus.rs2_addr)) begin
          w_rs2Value = w_wbData;
        end else begin
          w_rs2Value = r_regs[bus.rd_warp][bus.rs2_addr];
        end
      end
    end
  end

  warp_scalar_reg_file_reg_scoreboard #(
    .NUM_WARPS (NUM_WARPS),
    .NUM_REGS  (NUM_REGS)
  ) u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .i_setValid   (bus.issue_valid),
    .i_setWarp    (bus.issue_warp),
    .i_setReg     (bus.issue_rd),
    .i_clrValid   (bus.wb_valid && w_wbLegal),
    .i_clrWarp    (bus.wb_warp),
    .i_clrReg     (bus.wb_rd),
    .i_lookupWarp (bus.rd_warp),
    .i_lookupReg1 (bus.rs1_addr),
    .i_lookupReg2 (bus.rs2_addr),
    .o_pending1   (w_pending1),
    .o_pending2   (w_pending2)
  );

  // Register 1 of every warp resets to all ones so every lane starts enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        for (int r = 0; r < NUM_REGS; r++) begin
          r_regs[w][r] <= (r == EXECUTION_MASK_REG) ? '1 : '0;
        end
      end
    end else if (w_wbWrite) begin
      r_regs[bus.wb_warp][bus.wb_rd] <= w_wbData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_respValid  <= 1'b0;
      r_rs1Data    <= '0;
      r_rs2Data    <= '0;
      r_hazard     <= 1'b0;
      r_illegalMux <= 1'b0;
    end else begin
      r_respValid <= bus.rd_req_valid;
      if (bus.rd_req_valid) begin
        r_rs1Data <= w_rs1Value;
        r_rs2Data <= w_rs2Value;
        r_hazard  <= w_pending1 || w_pending2;
      end
      if (bus.wb_valid && !w_wbLegal) begin
        r_illegalMux <= 1'b1;
      end
    end
  end

  assign bus.rd_resp_valid = r_respValid;
  assign bus.rs1_data      = r_rs1Data;
  assign bus.rs2_data      = r_rs2Data;
  assign bus.rs_hazard     = r_hazard;
  assign bus.illegal_mux   = r_illegalMux;
  assign bus.exec_mask     = w_maskInRange ? r_regs[bus.mask_warp][EXECUTION_MASK_REG] : '0;

endmodule

// File: tb/tb_warp_scalar_reg_file.sv
// Scoreboard bench for warp_scalar_reg_file: directed cases, then random
// traffic against an array-based reference model of the register file rules.
module tb_warp_scalar_reg_file;
  import warp_scalar_reg_file_pkg::*;

  localparam int DW  = 32;
  localparam int NW  = 4;
  localparam int NR  = 32;
  localparam int PW  = 12;
  localparam int WID = 2;
  localparam int RID = 5;

  typedef struct {
    bit          rst;
    bit          rdReq;
    int          rdWarp;
    int          rs1;
    int          rs2;
    bit          issue;
    int          issueWarp;
    int          issueRd;
    bit          wb;
    int          wbWarp;
    int          wbRd;
    int          wbMux;
    logic [31:0] alu;
    logic [31:0] lsu;
    logic [31:0] imm;
    int          pc;
    logic [31:0] v2s;
    int          maskWarp;
  } stim_t;

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        hazard;
  } resp_t;

  logic clk;
  logic reset;

  warp_scalar_reg_file_if #(
    .DATA_WIDTH (DW),
    .NUM_WARPS  (NW),
    .NUM_REGS   (NR),
    .PC_WIDTH   (PW)
  ) bus ();

  warp_scalar_reg_file #(
    .DATA_WIDTH (DW),
    .NUM_WARPS  (NW),
    .NUM_REGS   (NR),
    .PC_WIDTH   (PW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] mRegs [NW][NR];
  bit          mPend [NW][NR];
  bit          mIllegal;
  bit          modelValid = 0;
  resp_t       expQ[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int w = 0; w < NW; w++) begin
      for (int r = 0; r < NR; r++) begin
        mRegs[w][r] = (r == 1) ? 32'hFFFF_FFFF : 32'h0;
        mPend[w][r] = 1'b0;
      end
    end
    mIllegal   = 1'b0;
    modelValid = 1'b1;
  endtask

  function automatic logic [31:0] modelRead(input int w, input int r, input bit legalWb,
                                            input stim_t s, input logic [31:0] wbVal);
    if (w >= NW || r == 0) return 32'h0;
    if (legalWb && s.wbWarp == w && s.wbRd == r) return wbVal;
    return mRegs[w][r];
  endfunction

  function automatic bit modelPendAfterClear(input int w, input int r, input bit legalWb, input stim_t s);
    if (w >= NW || r == 0) return 1'b0;
    if (legalWb && s.wbWarp == w && s.wbRd == r) return 1'b0;
    return mPend[w][r];
  endfunction

  task automatic modelStep(input stim_t s);
    bit          legalWb;
    logic [31:0] wbVal;
    resp_t       e;
    if (s.rst) begin
      modelReset();
      return;
    end
    legalWb = s.wb && (s.wbMux <= 4);
    case (s.wbMux)
      0:       wbVal = s.alu;
      1:       wbVal = s.lsu;
      2:       wbVal = s.imm;
      3:       wbVal = 32'((s.pc + 1) % 4096);
      4:       wbVal = s.v2s;
      default: wbVal = 32'h0;
    endcase
    if (s.rdReq) begin
      e.rs1    = modelRead(s.rdWarp, s.rs1, legalWb, s, wbVal);
      e.rs2    = modelRead(s.rdWarp, s.rs2, legalWb, s, wbVal);
      e.hazard = modelPendAfterClear(s.rdWarp, s.rs1, legalWb, s) ||
                 modelPendAfterClear(s.rdWarp, s.rs2, legalWb, s);
      expQ.push_back(e);
    end
    if (s.wb && s.wbMux > 4) mIllegal = 1'b1;
    if (legalWb && s.wbWarp < NW && s.wbRd != 0) begin
      mRegs[s.wbWarp][s.wbRd] = wbVal;
      mPend[s.wbWarp][s.wbRd] = 1'b0;
    end
    if (s.issue && s.issueWarp < NW && s.issueRd != 0) begin
      mPend[s.issueWarp][s.issueRd] = 1'b1;
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    @(posedge clk);
    #1;
    reset                     = s.rst;
    bus.rd_req_valid          = s.rdReq;
    bus.rd_warp               = WID'(s.rdWarp);
    bus.rs1_addr              = RID'(s.rs1);
    bus.rs2_addr              = RID'(s.rs2);
    bus.issue_valid           = s.issue;
    bus.issue_warp            = WID'(s.issueWarp);
    bus.issue_rd              = RID'(s.issueRd);
    bus.wb_valid              = s.wb;
    bus.wb_warp               = WID'(s.wbWarp);
    bus.wb_rd                 = RID'(s.wbRd);
    bus.wb_mux                = reg_input_mux_t'(3'(s.wbMux));
    bus.alu_out               = s.alu;
    bus.lsu_out               = s.lsu;
    bus.wb_immediate          = s.imm;
    bus.pc                    = PW'(s.pc);
    bus.vector_to_scalar_data = s.v2s;
    bus.mask_warp             = WID'(s.maskWarp);
    #1;
    if (modelValid) begin
      checkOutput("execMask", bus.exec_mask, (s.maskWarp < NW) ? mRegs[s.maskWarp][1] : 32'h0);
      checkOutput("illegalMux", {31'h0, bus.illegal_mux}, {31'h0, mIllegal});
    end
    modelStep(s);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  always @(negedge clk) begin : monitor
    resp_t e;
    if (bus.rd_resp_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpectedResp: got rd_resp_valid=1, expected no response at %0t", $time);
      end else begin
        e = expQ.pop_front();
        checkOutput("rs1Data", bus.rs1_data, e.rs1);
        checkOutput("rs2Data", bus.rs2_data, e.rs2);
        checkOutput("rsHazard", {31'h0, bus.rs_hazard}, {31'h0, e.hazard});
      end
    end
  end

  initial begin
    stim_t s;
    $display("[TB] starting warp_scalar_reg_file bench");

    s = idle(); s.rst = 1;
    applyStimulus(s);
    applyStimulus(s);

    s = idle(); s.rdReq = 1; s.rdWarp = 2; s.rs1 = 1; s.rs2 = 5; s.maskWarp = 2;
    applyStimulus(s);

    s = idle(); s.rdReq = 1; s.rdWarp = 1; s.rs1 = 7;
    s.wb = 1; s.wbWarp = 1; s.wbRd = 7; s.wbMux = 0; s.alu = 32'h1234;
    applyStimulus(s);
    s = idle(); s.rdReq = 1; s.rdWarp = 0; s.rs1 = 7; s.rs2 = 7;
    applyStimulus(s);

    s = idle(); s.issue = 1; s.issueWarp = 3; s.issueRd = 4;
    applyStimulus(s);
    s = idle(); s.rdReq = 1; s.rdWarp = 3; s.rs1 = 1; s.rs2 = 4;
    applyStimulus(s);
    s = idle(); s.rdReq = 1; s.rdWarp = 3; s.rs2 = 4;
    s.wb = 1; s.wbWarp = 3; s.wbRd = 4; s.wbMux = 1; s.lsu = 32'hABCD;
    applyStimulus(s);

    s = idle(); s.issue = 1; s.issueWarp = 0; s.issueRd = 9;
    s.wb = 1; s.wbWarp = 0; s.wbRd = 9; s.wbMux = 0; s.alu = 32'h99;
    applyStimulus(s);
    s = idle(); s.rdReq = 1; s.rdWarp = 0; s.rs1 = 9;
    applyStimulus(s);
    s = idle(); s.wb = 1; s.wbWarp = 0; s.wbRd = 0; s.wbMux = 2; s.imm = 32'hDEAD;
    applyStimulus(s);
    s = idle(); s.rdReq = 1; s.rdWarp = 0; s.rs1 = 0; s.rs2 = 9;
    applyStimulus(s);

    s = idle(); s.wb = 1; s.wbWarp = 2; s.wbRd = 3; s.wbMux = 3; s.pc = 12'hFFF;
    applyStimulus(s);
    s = idle(); s.rdReq = 1; s.rdWarp = 2; s.rs1 = 3;
    applyStimulus(s);
    s = idle(); s.wb = 1; s.wbWarp = 2; s.wbRd = 3; s.wbMux = 6; s.alu = 32'h5555;
    applyStimulus(s);
    s = idle(); s.rdReq = 1; s.rdWarp = 2; s.rs1 = 3;
    applyStimulus(s);

    s = idle(); s.wb = 1; s.wbWarp = 1; s.wbRd = 1; s.wbMux = 0; s.alu = 32'hF0F0; s.maskWarp = 1;
    applyStimulus(s);
    s = idle(); s.maskWarp = 1;
    applyStimulus(s);

    for (int i = 0; i < 400; i++) begin
      s           = idle();
      s.rst       = ($urandom_range(0, 99) == 0);
      s.rdReq     = ($urandom_range(0, 3) != 0);
      s.rdWarp    = $urandom_range(0, NW - 1);
      s.rs1       = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NR - 1) : $urandom_range(0, 7);
      s.rs2       = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NR - 1) : $urandom_range(0, 7);
      s.issue     = ($urandom_range(0, 2) == 0);
      s.issueWarp = $urandom_range(0, NW - 1);
      s.issueRd   = $urandom_range(0, 7);
      s.wb        = ($urandom_range(0, 1) == 0);
      s.wbWarp    = $urandom_range(0, NW - 1);
      s.wbRd      = $urandom_range(0, 7);
      s.wbMux     = ($urandom_range(0, 39) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
      s.alu       = $urandom;
      s.lsu       = $urandom;
      s.imm       = $urandom;
      s.pc        = ($urandom_range(0, 7) == 0) ? 4095 : $urandom_range(0, 4095);
      s.v2s       = $urandom;
      s.maskWarp  = $urandom_range(0, NW - 1);
      applyStimulus(s);
    end

    s = idle(); s.rst = 1; s.rdReq = 1; s.rdWarp = 1; s.rs1 = 7; s.rs2 = 1;
    applyStimulus(s);
    s = idle();
    applyStimulus(s);
    checkOutput("respAfterReset", {31'h0, bus.rd_resp_valid}, 32'h0);
    for (int w = 0; w < NW; w++) begin
      s = idle(); s.rdReq = 1; s.rdWarp = w; s.rs1 = 1; s.rs2 = $urandom_range(2, 7); s.maskWarp = w;
      applyStimulus(s);
    end

    s = idle();
    applyStimulus(s);
    applyStimulus(s);
    @(negedge clk);
    #1;
    checkOutput("queueEmpty", 32'(expQ.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/warp_scalar_reg_file.md
Name: warp_scalar_reg_file

Overview:
Multi-warp scalar register file for the lock-in compute core. It replaces per-warp register instances with one banked array holding NUM_WARPS x NUM_REGS scalar registers. It adds registered dual reads with write-to-read bypass, a per-register pending-write scoreboard for hazard detection, and per-warp execution-mask export. It sits between the warp scheduler/decoder (read and issue side) and the ALU/LSU/vector-reduction write-back path.

Parameters:
DATA_WIDTH, 32, register width in bits
NUM_WARPS, 4, number of warps (>=1; need not be a power of 2)
NUM_REGS, 32, registers per warp (power of 2, >=4)
PC_WIDTH, 12, instruction memory address width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
rd_req_valid  in  1  read request
rd_warp  in  WID  warp of read; WID = max(1, clog2(NUM_WARPS))
rs1_addr  in  RID  source 1 index; RID = clog2(NUM_REGS)
rs2_addr  in  RID  source 2 index
rd_resp_valid  out  1  read data valid
rs1_data  out  DATA_WIDTH  source 1 value
rs2_data  out  DATA_WIDTH  source 2 value
rs_hazard  out  1  a source was pending at request time
issue_valid  in  1  instruction issued that will write issue_rd
issue_warp  in  WID  issuing warp
issue_rd  in  RID  destination being reserved
wb_valid  in  1  write-back strobe
wb_warp  in  WID  write-back warp
wb_rd  in  RID  destination register
wb_mux  in  reg_input_mux_t  write source select
alu_out  in  DATA_WIDTH  ALU result
lsu_out  in  DATA_WIDTH  load result
wb_immediate  in  DATA_WIDTH  decoded immediate
pc  in  PC_WIDTH  PC of the writing instruction
vector_to_scalar_data  in  DATA_WIDTH  vector reduction result
mask_warp  in  WID  warp whose mask is exported
exec_mask  out  DATA_WIDTH  register 1 of mask_warp, combinational
illegal_mux  out  1  sticky flag: invalid wb_mux seen

Behaviour:
- Clock clk; reset is synchronous, active-high.
- Reset, every warp: reg0 = 0, reg1 = all ones, others = 0. Pending bits = 0. rd_resp_valid = 0. rs1_data, rs2_data = 0. rs_hazard = 0. illegal_mux = 0.
- Reset mid-operation discards any in-flight response. The cycle after reset deasserts, rd_resp_valid = 0.
- Read latency is 1 cycle. If rd_req_valid is high in cycle N, then in N+1 rd_resp_valid = 1 with data. With no request, rd_resp_valid = 0 and the data outputs hold their last values.
- Reg0 always reads 0. Writes to reg0 are ignored, as are issue reservations of reg0.
- Bypass: if wb_valid is high in the same cycle as the request, with the same warp, same nonzero register, and a legal mux, the response carries the new write-back value.
- Write-back: on wb_valid with wb_rd != 0, the selected value is stored at the clock edge. Sources:
  - ALU_OUT -> alu_out
  - LSU_OUT -> lsu_out
  - IMMEDIATE -> wb_immediate
  - PC_PLUS_1 -> (pc+1) mod 2^PC_WIDTH, zero-extended
  - VECTOR_TO_SCALAR -> vector_to_scalar_data
- Any other wb_mux value: no write, pending bit not cleared, illegal_mux set until reset.
- Scoreboard:
  - issue_valid sets pending[issue_warp][issue_rd].
  - A legal wb_valid clears pending[wb_warp][wb_rd].
  - Same-cycle issue and write-back to the same entry: the entry stays set (the new reservation wins).
- rs_hazard is registered with the response. It is 1 if either nonzero source was pending in the request cycle, after applying that cycle's write-back clear and before applying that cycle's issue set.
- Warp index >= NUM_WARPS:
  - writes and issues are ignored;
  - reads return 0 with rs_hazard = 0;
  - exec_mask returns 0.
- exec_mask reads stored state only, with no bypass. A write to reg1 appears on exec_mask the cycle after the write-back.

Decomposition:
- Shared package (common.sv): reg_input_mux_t (existing), ZERO_REG = 0, EXECUTION_MASK_REG = 1, warp_id_t, reg_addr_t.
- Sub-module reg_scoreboard holds the NUM_WARPS x NUM_REGS pending-bit array with set/clear ports and two combinational lookups. The parent holds the data array, write mux, bypass and output registers.

Test Plan:
- Reset, then read warp 2 regs 1 and 5 -> one cycle later rd_resp_valid = 1, rs1_data = 0xFFFFFFFF, rs2_data = 0, exec_mask(mask_warp = 2) = 0xFFFFFFFF.
- wb warp 1 rd 7, ALU_OUT, alu_out = 0x1234, plus a same-cycle read of warp 1 rs1 = 7 -> response 0x1234 (bypass). A warp 0 read of reg 7 returns 0 (warp isolation).
- issue warp 3 rd 4; next cycle read rs2 = 4 -> rs_hazard = 1. Then wb LSU_OUT = 0xABCD to warp 3 rd 4 with a same-cycle read -> rs_hazard = 0 and data 0xABCD.
- Same-cycle issue and wb to warp 0 rd 9 -> a later read reports rs_hazard = 1. wb to rd 0 with 0xDEAD -> reg0 still reads 0.
- PC_PLUS_1 with pc = 0xFFF (PC_WIDTH 12) -> register = 0x00000000. Then wb_mux set to an invalid encoding -> no write and illegal_mux = 1, held until reset.
- A read request in the same cycle as a reset assertion -> rd_resp_valid = 0 the next cycle, and all registers are back at their reset values.
